sa_axi4_master: RTL and testbench

// - Single-transaction AXI4-full master for the systolic-array accelerator: moves one data word between the local datapath and off-chip memory.
// - STORE: writes c_m00_wdata to base+addra. LOAD: reads base+addrb into c_m00_rdata.
// - Each transaction is started by a pulse on m00_axi_init_axi_txn and ends with m00_axi_txn_done.
// - Sits between the TPU controller and an AXI4 memory slave (the BRAM-backed sa_axi4_slave).

---
 rtl/sa_axi4_master_pkg.sv | 29 ++
 rtl/sa_axi4_master_if.sv | 84 ++++++++
 rtl/sa_axi4_master.sv | 179 +++++++++++++++++
 tb/tb_sa_axi4_master.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_axi4_master_pkg.sv
// Shared definitions for sa_axi4_master: controller mode codes, AXI burst/response codes, FSM states.
package sa_axi4_master_pkg;

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_LOAD  = 2'd1;
  localparam logic [1:0] M_STORE = 2'd2;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] CACHE_MODIFIABLE = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/sa_axi4_master_if.sv
// AXI4-full bus between sa_axi4_master and its memory slave; master drives requests, slave drives readies/responses.
interface sa_axi4_master_if #(
  parameter int ID_W     = 1,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 128,
  parameter int AWUSER_W = 1,
  parameter int ARUSER_W = 1,
  parameter int WUSER_W  = 1,
  parameter int RUSER_W  = 1,
  parameter int BUSER_W  = 1
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [AWUSER_W-1:0] awuser;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [WUSER_W-1:0]  wuser;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic [BUSER_W-1:0]  buser;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [RUSER_W-1:0]  ruser;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/sa_axi4_master.sv
// Single-transaction AXI4 master: one STORE (AW+W+B) or LOAD (AR+R) per rising edge of init; valids rise one cycle after start.
// Every valid holds with a stable payload until its ready; all outputs are registered, so no ready/valid input reaches an output combinationally.
module sa_axi4_master
  import sa_axi4_master_pkg::*;
#(
  parameter logic [31:0] C_M00_AXI_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
  parameter int C_M00_AXI_BURST_LEN     = 16,
  parameter int C_M00_AXI_ID_WIDTH      = 1,
  parameter int C_M00_AXI_ADDR_WIDTH    = 32,
  parameter int C_M00_AXI_DATA_WIDTH    = 128,
  parameter int C_M00_AXI_AWUSER_WIDTH  = 1,
  parameter int C_M00_AXI_ARUSER_WIDTH  = 1,
  parameter int C_M00_AXI_WUSER_WIDTH   = 1,
  parameter int C_M00_AXI_RUSER_WIDTH   = 1,
  parameter int C_M00_AXI_BUSER_WIDTH   = 1
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_areset,
  input  logic [1:0]                      c_m00_mode,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0] c_m00_off_mem_addra,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0] c_m00_off_mem_addrb,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] c_m00_wdata,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] c_m00_rdata,
  input  logic                            m00_axi_init_axi_txn,
  output logic                            m00_axi_txn_done,
  output logic                            m00_axi_error,
  sa_axi4_master_if.master                m00_axi
);

  localparam int ADDR_W = C_M00_AXI_ADDR_WIDTH;
  localparam int DATA_W = C_M00_AXI_DATA_WIDTH;
  localparam int BEAT_W = $clog2(C_M00_AXI_BURST_LEN) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_M00_AXI_BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(C_M00_AXI_TARGET_SLAVE_BASE_ADDR);

  state_t              state;
  logic                init_q;
  logic                start;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BEAT_W-1:0]   beat;
  logic                awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic                aw_fin, w_fin;
  logic                unused_in;

  assign start = m00_axi_init_axi_txn & ~init_q;

  // AW and W finish independently; each is finished once its valid has dropped or is handshaking now.
  assign aw_fin = ~awvalid_q | m00_axi.awready;
  assign w_fin  = ~wvalid_q  | (m00_axi.wready & wlast_q);

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state            <= S_IDLE;
      init_q           <= 1'b0;
      awaddr_q         <= '0;
      araddr_q         <= '0;
      wdata_q          <= '0;
      beat             <= '0;
      awvalid_q        <= 1'b0;
      wvalid_q         <= 1'b0;
      wlast_q          <= 1'b0;
      bready_q         <= 1'b0;
      arvalid_q        <= 1'b0;
      rready_q         <= 1'b0;
      c_m00_rdata      <= '0;
      m00_axi_txn_done <= 1'b0;
      m00_axi_error    <= 1'b0;
    end else begin
      init_q <= m00_axi_init_axi_txn;
      case (state)
        S_IDLE: begin
          if (start) begin
            m00_axi_txn_done <= 1'b0;
            m00_axi_error    <= 1'b0;
            awaddr_q         <= BASE + c_m00_off_mem_addra;
            araddr_q         <= BASE + c_m00_off_mem_addrb;
            wdata_q          <= c_m00_wdata;
            beat             <= '0;
            case (c_m00_mode)
              M_STORE: begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                wlast_q   <= (LAST_BEAT == '0);
                state     <= S_WR;
              end
              M_LOAD: begin
                arvalid_q <= 1'b1;
                state     <= S_RD_ADDR;
              end
              default: state <= S_DONE;
            endcase
          end
        end
        S_WR: begin
          if (awvalid_q && m00_axi.awready) awvalid_q <= 1'b0;
          if (wvalid_q && m00_axi.wready) begin
            beat    <= beat + 1'b1;
            wlast_q <= ((beat + 1'b1) == LAST_BEAT);
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
            end
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state    <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m00_axi.bvalid) begin
            bready_q <= 1'b0;
            if (resp_is_err(m00_axi.bresp)) m00_axi_error <= 1'b1;
            state <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (m00_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m00_axi.rvalid) begin
            c_m00_rdata <= m00_axi.rdata;
            if (resp_is_err(m00_axi.rresp)) m00_axi_error <= 1'b1;
            if (m00_axi.rlast) begin
              rready_q <= 1'b0;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          m00_axi_txn_done <= 1'b1;
          state            <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m00_axi.awid    = '0;
  assign m00_axi.awaddr  = awaddr_q;
  assign m00_axi.awlen   = 8'(C_M00_AXI_BURST_LEN - 1);
  assign m00_axi.awsize  = 3'($clog2(DATA_W / 8));
  assign m00_axi.awburst = BURST_INCR;
  assign m00_axi.awlock  = 1'b0;
  assign m00_axi.awcache = CACHE_MODIFIABLE;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awqos   = 4'b0000;
  assign m00_axi.awuser  = '0;
  assign m00_axi.awvalid = awvalid_q;

  assign m00_axi.wdata   = wdata_q;
  assign m00_axi.wstrb   = '1;
  assign m00_axi.wlast   = wlast_q;
  assign m00_axi.wuser   = '0;
  assign m00_axi.wvalid  = wvalid_q;
  assign m00_axi.bready  = bready_q;

  assign m00_axi.arid    = '0;
  assign m00_axi.araddr  = araddr_q;
  assign m00_axi.arlen   = 8'(C_M00_AXI_BURST_LEN - 1);
  assign m00_axi.arsize  = 3'($clog2(DATA_W / 8));
  assign m00_axi.arburst = BURST_INCR;
  assign m00_axi.arlock  = 1'b0;
  assign m00_axi.arcache = CACHE_MODIFIABLE;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arqos   = 4'b0000;
  assign m00_axi.aruser  = '0;
  assign m00_axi.arvalid = arvalid_q;
  assign m00_axi.rready  = rready_q;

  assign unused_in = ^{m00_axi.bid, m00_axi.buser, m00_axi.bresp[0],
                       m00_axi.rid, m00_axi.ruser, m00_axi.rresp[0]};

endmodule

// File: tb/tb_sa_axi4_master.sv
// Bench for sa_axi4_master with a behavioural BRAM slave and a high-level memory/response reference model.
module tb_sa_axi4_master;
  import sa_axi4_master_pkg::*;

  localparam int AW = 32;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] wdata, rdata;
  logic          init, done, err;

  always #5 clk = ~clk;

  sa_axi4_master_if #(.ID_W(1), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sa_axi4_master #(
    .C_M00_AXI_TARGET_SLAVE_BASE_ADDR(32'h0),
    .C_M00_AXI_BURST_LEN(1),
    .C_M00_AXI_ID_WIDTH(1),
    .C_M00_AXI_ADDR_WIDTH(AW),
    .C_M00_AXI_DATA_WIDTH(DW),
    .C_M00_AXI_AWUSER_WIDTH(1),
    .C_M00_AXI_ARUSER_WIDTH(1),
    .C_M00_AXI_WUSER_WIDTH(1),
    .C_M00_AXI_RUSER_WIDTH(1),
    .C_M00_AXI_BUSER_WIDTH(1)
  ) dut (
    .m00_axi_aclk(clk),
    .m00_axi_areset(rst),
    .c_m00_mode(mode),
    .c_m00_off_mem_addra(addra),
    .c_m00_off_mem_addrb(addrb),
    .c_m00_wdata(wdata),
    .c_m00_rdata(rdata),
    .m00_axi_init_axi_txn(init),
    .m00_axi_txn_done(done),
    .m00_axi_error(err),
    .m00_axi(bus.master)
  );

  // ---------------- behavioural slave ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]    bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  int            aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic          aw_got, w_got, ar_got;
  int            aw_hs = 0, w_hs = 0, b_hs = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [7:0]    cap_awlen;
  logic [2:0]    cap_awsize;
  logic [1:0]    cap_awburst;
  logic [DW-1:0] cap_wdata;
  logic [15:0]   cap_wstrb;
  logic          cap_wlast;

  assign bus.bid   = '0;
  assign bus.buser = '0;
  assign bus.rid   = '0;
  assign bus.ruser = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.awready <= 1'b0; bus.wready <= 1'b0; bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.arready <= 1'b0; bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= 2'b00; bus.rlast <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        bus.awready <= 1'b0; aw_got <= 1'b1; aw_cnt <= 0; aw_hs <= aw_hs + 1;
        cap_awaddr <= bus.awaddr; cap_awlen <= bus.awlen; cap_awsize <= bus.awsize; cap_awburst <= bus.awburst;
      end else if (bus.awvalid && !aw_got) begin
        if (aw_cnt >= aw_dly) bus.awready <= 1'b1; else aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid && bus.wready) begin
        bus.wready <= 1'b0; w_got <= 1'b1; w_cnt <= 0; w_hs <= w_hs + 1;
        cap_wdata <= bus.wdata; cap_wstrb <= bus.wstrb; cap_wlast <= bus.wlast;
      end else if (bus.wvalid && !w_got) begin
        if (w_cnt >= w_dly) bus.wready <= 1'b1; else w_cnt <= w_cnt + 1;
      end
      if (bus.bvalid && bus.bready) begin
        bus.bvalid <= 1'b0; b_hs <= b_hs + 1;
      end else if (aw_got && w_got && !bus.bvalid) begin
        mem[cap_awaddr] = cap_wdata;
        bus.bvalid <= 1'b1; bus.bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        bus.arready <= 1'b0; ar_got <= 1'b1; ar_cnt <= 0; cap_araddr <= bus.araddr;
      end else if (bus.arvalid && !ar_got) begin
        if (ar_cnt >= ar_dly) bus.arready <= 1'b1; else ar_cnt <= ar_cnt + 1;
      end
      if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0; bus.rlast <= 1'b0;
      end else if (ar_got && !bus.rvalid) begin
        if (r_cnt >= r_dly) begin
          bus.rvalid <= 1'b1; bus.rlast <= 1'b1; bus.rresp <= rresp_cfg;
          bus.rdata  <= mem.exists(cap_araddr) ? mem[cap_araddr] : '0;
          ar_got <= 1'b0; r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- monitor: payload stability and valid activity ----------------
  int            valid_cycles = 0, stab_err = 0;
  logic          aw_pend = 1'b0, w_pend = 1'b0;
  logic [AW-1:0] prev_awaddr;
  logic [DW-1:0] prev_wdata;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.awvalid || bus.wvalid || bus.arvalid) valid_cycles++;
      if (aw_pend && (!bus.awvalid || bus.awaddr !== prev_awaddr)) stab_err++;
      if (w_pend && (!bus.wvalid || bus.wdata !== prev_wdata)) stab_err++;
      aw_pend = bus.awvalid && !bus.awready;
      w_pend  = bus.wvalid && !bus.wready;
      prev_awaddr = bus.awaddr;
      prev_wdata  = bus.wdata;
    end else begin
      aw_pend = 1'b0;
      w_pend  = 1'b0;
    end
  end

  // ---------------- checking and reference model ----------------
  int            n_vec = 0, n_err = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_rdata = '0;
  logic          err_after_start;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  // Issues one start pulse, scrambles the controller inputs afterwards, and waits (bounded) for done.
  task automatic run_txn(input logic [1:0] m, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] d, output int cyc);
    @(negedge clk);
    mode = m; addra = a; addrb = b; wdata = d; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    mode = 2'($urandom_range(0, 3)); addra = $urandom; addrb = $urandom;
    wdata = {$urandom, $urandom, $urandom, $urandom};
    err_after_start = err;
    check("busy_after_start", done, 1'b0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("txn_done", done, 1'b1);
  endtask

  task automatic do_store(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
    int cyc, aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    bresp_cfg = resp;
    run_txn(M_STORE, a, $urandom, d, cyc);
    bresp_cfg = RESP_OKAY;
    ref_mem[a] = d;
    check({tag, "_awaddr"}, cap_awaddr, a);
    check({tag, "_wdata"}, cap_wdata, d);
    check({tag, "_beats"}, {aw_hs - aw0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
    check({tag, "_error"}, err, resp[1]);
    check({tag, "_rdata_hold"}, rdata, exp_rdata);
  endtask

  task automatic do_load(input string tag, input logic [AW-1:0] b, input logic [1:0] resp);
    int cyc;
    rresp_cfg = resp;
    run_txn(M_LOAD, $urandom, b, '0, cyc);
    rresp_cfg = RESP_OKAY;
    exp_rdata = model_read(b);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_error"}, err, resp[1]);
  endtask

  initial begin
    int cyc, v0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0] resp;
    rst = 1'b1; init = 1'b0; mode = M_IDLE; addra = '0; addrb = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, bus.wlast}, '0);
    check("rst_status", {done, err}, 2'b00);
    check("rst_rdata", rdata, '0);
    rst = 1'b0;

    // i*i table: store then read back, with a full AW/W field check on each store
    for (int i = 0; i < 256; i += 16) begin
      do_store("sq_store", AW'(i), DW'(i * i), RESP_OKAY);
      check("sq_fields", {cap_awlen, 5'(cap_awsize), cap_awburst, cap_wstrb, cap_wlast},
            {8'd0, 5'd4, 2'b01, 16'hFFFF, 1'b1});
    end
    for (int i = 0; i < 256; i += 16) do_load("sq_load", AW'(i), RESP_OKAY);

    // slave stalls AW for 5 cycles and W for 2: payload must stay put
    aw_dly = 5; w_dly = 2;
    v0 = stab_err;
    do_store("stall", 32'h1000, {$urandom, $urandom, $urandom, $urandom}, RESP_OKAY);
    check("stall_stable", stab_err - v0, 0);
    aw_dly = 0; w_dly = 0;
    do_load("stall_rb", 32'h1000, RESP_OKAY);

    // error reporting and clearing on the next start
    do_store("slverr", 32'h2000, DW'(32'hDEAD), RESP_SLVERR);
    do_store("after_err", 32'h2010, DW'(32'hBEEF), RESP_OKAY);
    check("err_cleared_at_start", err_after_start, 1'b0);
    do_load("rd_err", 32'h2010, RESP_DECERR);

    // idle / reserved mode: no bus activity, quick done
    for (int k = 0; k < 2; k++) begin
      v0 = valid_cycles;
      run_txn((k == 0) ? M_IDLE : 2'd3, $urandom, $urandom, '0, cyc);
      check("idle_latency", (cyc <= 2), 1'b1);
      check("idle_no_valids", valid_cycles - v0, 0);
      check("idle_rdata_hold", rdata, exp_rdata);
    end

    // randomized mix of ops, delays and responses against the model
    for (int n = 0; n < 40; n++) begin
      aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4);
      ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 4);
      a = AW'($urandom_range(0, 31) * 16);
      d = {$urandom, $urandom, $urandom, $urandom};
      resp = ($urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
      case ($urandom_range(0, 2))
        0: do_store("rnd_store", a, d, resp);
        1: do_load("rnd_load", a, resp);
        default: begin
          run_txn(M_IDLE, a, a, d, cyc);
          check("rnd_idle", {rdata, err}, {exp_rdata, 1'b0});
        end
      endcase
    end
    ar_dly = 0; r_dly = 0; w_dly = 0;

    // reset while AW is pending aborts at once; a following LOAD still works
    aw_dly = 8;
    @(negedge clk);
    mode = M_STORE; addra = 32'h3000; wdata = DW'(32'h1234); init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    for (int k = 0; k < 20 && !bus.awvalid; k++) @(negedge clk);
    check("pre_rst_awvalid", bus.awvalid, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {bus.awvalid, bus.wvalid, done, err}, 4'b0000);
    check("mid_rst_rdata", rdata, '0);
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b0; aw_dly = 0;
    do_load("post_rst_load", 32'h0030, RESP_OKAY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
